// File: rtl/ahb_lite_bus_arbiter.sv
// Round-robin AHB-lite bus arbiter: hands the shared bus between masters only on
// legal transfer boundaries, honours locked sequences and limits unlocked streams.
module ahb_lite_bus_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int MW             = $clog2(NUM_MASTERS),
   parameter int DEFAULT_MASTER = 0,
   parameter int MAX_HOLD       = 16
) (
   input  logic                     hclk,
   input  logic                     hreset,
   input  logic [NUM_MASTERS-1:0]   hbusreq,
   input  logic [NUM_MASTERS-1:0]   hlock,
   input  logic [2*NUM_MASTERS-1:0] htrans_m,
   input  logic                     hready,
   output logic [NUM_MASTERS-1:0]   hgrant,
   output logic [MW-1:0]            hmaster,
   output logic [MW-1:0]            hmaster_d,
   output logic                     hmastlock,
   output logic [1:0]               arb_state
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [MW-1:0]          DefaultIdx   = MW'(DEFAULT_MASTER);
   localparam logic [HW-1:0]          HoldMax      = HW'(MAX_HOLD);
   localparam logic [NUM_MASTERS-1:0] DefaultGrant = NUM_MASTERS'(1) << DEFAULT_MASTER;

   typedef enum logic [1:0] {
      PARK   = 2'd0,
      OWNED  = 2'd1,
      LOCKED = 2'd2
   } arbState_e;

   arbState_e              state_q, state_d;
   logic [MW-1:0]          owner_q, owner_d;
   logic [MW-1:0]          ownerData_q;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic                   lock_q, lock_d;
   logic [HW-1:0]          holdCnt_q, holdCnt_d;

   logic [1:0]    ownHtrans;
   logic          ownReq;
   logic          ownLock;
   logic          boundary;
   logic          holdSat;
   logic          rearb;
   logic          found;
   logic [MW-1:0] winner;
   logic          winnerLock;
   int            scanIdx;

   // Pick out the current address-phase owner's htrans, request and lock.
   always_comb begin
      ownHtrans = 2'b00;
      ownReq    = 1'b0;
      ownLock   = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (owner_q == MW'(i)) begin
            ownHtrans = htrans_m[2*i +: 2];
            ownReq    = hbusreq[i];
            ownLock   = hlock[i];
         end
      end
   end

   // IDLE and NONSEQ both have bit 0 clear; BUSY/SEQ must never be interrupted.
   assign boundary = hready && !ownHtrans[0];
   assign holdSat  = (holdCnt_q >= HoldMax);

   // Round-robin scan starting after the owner, so the owner is considered last.
   always_comb begin
      found      = 1'b0;
      winner     = owner_q;
      winnerLock = 1'b0;
      scanIdx    = 0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         scanIdx = (int'(owner_q) + k) % NUM_MASTERS;
         if (!found && hbusreq[scanIdx]) begin
            found      = 1'b1;
            winner     = MW'(scanIdx);
            winnerLock = hlock[scanIdx];
         end
      end
   end

   // Ownership FSM. An owner idling while others wait yields the bus; a locked
   // owner is never forced off, even once its hold budget is spent.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rearb     = 1'b0;
      holdCnt_d = holdCnt_q;
      if (boundary) begin
         case (state_q)
            PARK:    rearb = 1'b1;
            OWNED:   rearb = !ownReq || (!ownLock && ((ownHtrans == 2'b00) || holdSat));
            LOCKED:  rearb = !ownLock;
            default: rearb = 1'b1;
         endcase
         if (rearb) begin
            if (found) begin
               owner_d = winner;
               state_d = winnerLock ? LOCKED : OWNED;
            end else begin
               owner_d = DefaultIdx;
               state_d = PARK;
            end
         end else if ((state_q == OWNED) && ownLock) begin
            state_d = LOCKED;
         end
      end
      if (boundary && (rearb || (state_d != OWNED))) begin
         holdCnt_d = '0;
      end else if ((state_q == OWNED) && hready && ownHtrans[1] && !holdSat) begin
         holdCnt_d = holdCnt_q + HW'(1);
      end
   end

   always_comb begin
      grant_d = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         grant_d[i] = (owner_d == MW'(i));
      end
      lock_d = (state_d == LOCKED);
   end

   // Data-phase owner trails the address-phase owner and freezes in wait states.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q     <= PARK;
         owner_q     <= DefaultIdx;
         ownerData_q <= DefaultIdx;
         grant_q     <= DefaultGrant;
         lock_q      <= 1'b0;
         holdCnt_q   <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         grant_q   <= grant_d;
         lock_q    <= lock_d;
         holdCnt_q <= holdCnt_d;
         if (hready) begin
            ownerData_q <= owner_q;
         end
      end
   end

   assign hgrant    = grant_q;
   assign hmaster   = owner_q;
   assign hmaster_d = ownerData_q;
   assign hmastlock = lock_q;
   assign arb_state = state_q;

endmodule

// File: tb/tb_ahb_lite_bus_arbiter.sv
// Directed bench for ahb_lite_bus_arbiter: a vector table for the basic handovers
// plus hand-written sequences for locking, hold-limit, round-robin and reset.
module tb_ahb_lite_bus_arbiter;

   logic       hclk = 1'b0;
   logic       hreset;
   logic [3:0] hbusreq;
   logic [3:0] hlock;
   logic [7:0] htrans_m;
   logic       hready;
   logic [3:0] hgrant;
   logic [1:0] hmaster;
   logic [1:0] hmaster_d;
   logic       hmastlock;
   logic [1:0] arb_state;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [3:0] req;
      logic [3:0] lock;
      logic [7:0] htrans;
      logic       rdy;
      logic [3:0] expGrant;
      logic [1:0] expMaster;
      logic [1:0] expMasterD;
      logic       expLock;
      logic [1:0] expState;
   } vec_t;

   vec_t vecs[$];

   ahb_lite_bus_arbiter #(
      .NUM_MASTERS(4),
      .MW(2),
      .DEFAULT_MASTER(0),
      .MAX_HOLD(16)
   ) dut (
      .hclk(hclk),
      .hreset(hreset),
      .hbusreq(hbusreq),
      .hlock(hlock),
      .htrans_m(htrans_m),
      .hready(hready),
      .hgrant(hgrant),
      .hmaster(hmaster),
      .hmaster_d(hmaster_d),
      .hmastlock(hmastlock),
      .arb_state(arb_state)
   );

   // 10 time-unit bus clock.
   always #5 hclk = ~hclk;

   function automatic logic [7:0] ht(input int m, input logic [1:0] code);
      logic [7:0] v;
      v = '0;
      v[2*m +: 2] = code;
      return v;
   endfunction

   function automatic vec_t mkVec(input logic [3:0] req, input logic [3:0] lock,
                                  input logic [7:0] htrans, input logic rdy,
                                  input logic [3:0] eG, input logic [1:0] eM,
                                  input logic [1:0] eMD, input logic eL,
                                  input logic [1:0] eS);
      vec_t v;
      v.req = req; v.lock = lock; v.htrans = htrans; v.rdy = rdy;
      v.expGrant = eG; v.expMaster = eM; v.expMasterD = eMD;
      v.expLock = eL; v.expState = eS;
      return v;
   endfunction

   // Drive one cycle of inputs, then sample 1 unit after the rising edge.
   task automatic applyStimulus(input logic [3:0] req, input logic [3:0] lock,
                                input logic [7:0] htrans, input logic rdy);
      hbusreq  = req;
      hlock    = lock;
      htrans_m = htrans;
      hready   = rdy;
      @(posedge hclk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] eG,
                              input logic [1:0] eM, input logic [1:0] eMD,
                              input logic eL, input logic [1:0] eS);
      compared++;
      if ({hgrant, hmaster, hmaster_d, hmastlock, arb_state} !== {eG, eM, eMD, eL, eS}) begin
         mismatched++;
         $display("[TB] FAIL %s: got grant=%b master=%0d master_d=%0d mastlock=%b state=%0d, expected grant=%b master=%0d master_d=%0d mastlock=%b state=%0d",
                  name, hgrant, hmaster, hmaster_d, hmastlock, arb_state, eG, eM, eMD, eL, eS);
      end
   endtask

   initial begin
      logic [3:0] g;
      string      nm;

      // Park, grant master 2 from park, burst with wait states then handover to 3.
      vecs.push_back(mkVec(4'b0000, 4'b0000, 8'h00,          1'b1, 4'b0001, 2'd0, 2'd0, 1'b0, 2'd0));
      vecs.push_back(mkVec(4'b0100, 4'b0000, 8'h00,          1'b1, 4'b0100, 2'd2, 2'd0, 1'b0, 2'd1));
      vecs.push_back(mkVec(4'b0100, 4'b0000, ht(2, 2'b10),   1'b1, 4'b0100, 2'd2, 2'd2, 1'b0, 2'd1));
      vecs.push_back(mkVec(4'b0000, 4'b0000, 8'h00,          1'b1, 4'b0001, 2'd0, 2'd2, 1'b0, 2'd0));
      vecs.push_back(mkVec(4'b0000, 4'b0000, 8'h00,          1'b1, 4'b0001, 2'd0, 2'd0, 1'b0, 2'd0));
      vecs.push_back(mkVec(4'b0010, 4'b0000, 8'h00,          1'b1, 4'b0010, 2'd1, 2'd0, 1'b0, 2'd1));
      vecs.push_back(mkVec(4'b1010, 4'b0000, ht(1, 2'b10),   1'b1, 4'b0010, 2'd1, 2'd1, 1'b0, 2'd1));
      vecs.push_back(mkVec(4'b1000, 4'b0000, ht(1, 2'b11),   1'b0, 4'b0010, 2'd1, 2'd1, 1'b0, 2'd1));
      vecs.push_back(mkVec(4'b1000, 4'b0000, ht(1, 2'b11),   1'b0, 4'b0010, 2'd1, 2'd1, 1'b0, 2'd1));
      vecs.push_back(mkVec(4'b1000, 4'b0000, ht(1, 2'b11),   1'b1, 4'b0010, 2'd1, 2'd1, 1'b0, 2'd1));
      vecs.push_back(mkVec(4'b1000, 4'b0000, ht(1, 2'b11),   1'b1, 4'b0010, 2'd1, 2'd1, 1'b0, 2'd1));
      vecs.push_back(mkVec(4'b1000, 4'b0000, ht(1, 2'b11),   1'b1, 4'b0010, 2'd1, 2'd1, 1'b0, 2'd1));
      vecs.push_back(mkVec(4'b1000, 4'b0000, 8'h00,          1'b1, 4'b1000, 2'd3, 2'd1, 1'b0, 2'd1));
      vecs.push_back(mkVec(4'b0000, 4'b0000, 8'h00,          1'b1, 4'b0001, 2'd0, 2'd3, 1'b0, 2'd0));
      vecs.push_back(mkVec(4'b0010, 4'b0000, 8'h00,          1'b0, 4'b0001, 2'd0, 2'd3, 1'b0, 2'd0));
      vecs.push_back(mkVec(4'b0010, 4'b0000, 8'h00,          1'b1, 4'b0010, 2'd1, 2'd0, 1'b0, 2'd1));
      vecs.push_back(mkVec(4'b0000, 4'b0000, 8'h00,          1'b1, 4'b0001, 2'd0, 2'd1, 1'b0, 2'd0));

      hreset   = 1'b1;
      hbusreq  = '0;
      hlock    = '0;
      htrans_m = '0;
      hready   = 1'b1;
      repeat (2) @(posedge hclk);
      #1;
      checkOutput("reset_held", 4'b0001, 2'd0, 2'd0, 1'b0, 2'd0);
      hreset = 1'b0;
      #1;
      checkOutput("reset_released", 4'b0001, 2'd0, 2'd0, 1'b0, 2'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].req, vecs[i].lock, vecs[i].htrans, vecs[i].rdy);
         nm = $sformatf("vec%0d", i);
         checkOutput(nm, vecs[i].expGrant, vecs[i].expMaster, vecs[i].expMasterD,
                     vecs[i].expLock, vecs[i].expState);
      end

      // Master 0 locks alone, then holds the bus for 40 transfers against 1-3.
      applyStimulus(4'b0001, 4'b0001, 8'h00, 1'b1);
      checkOutput("lock_enter", 4'b0001, 2'd0, 2'd0, 1'b1, 2'd2);
      for (int t = 0; t < 40; t++) begin
         applyStimulus(4'b1111, 4'b0001, ht(0, 2'b10), 1'b1);
         nm = $sformatf("lock_hold%0d", t);
         checkOutput(nm, 4'b0001, 2'd0, 2'd0, 1'b1, 2'd2);
      end
      applyStimulus(4'b1111, 4'b0000, 8'h00, 1'b1);
      checkOutput("lock_release", 4'b0010, 2'd1, 2'd0, 1'b0, 2'd1);
      applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b1);
      checkOutput("lock_park", 4'b0001, 2'd0, 2'd1, 1'b0, 2'd0);

      // Master 1 streams NONSEQ singles with master 2 waiting: forced switch on the 17th.
      applyStimulus(4'b0010, 4'b0000, 8'h00, 1'b1);
      checkOutput("hold_grant", 4'b0010, 2'd1, 2'd0, 1'b0, 2'd1);
      for (int t = 1; t <= 17; t++) begin
         applyStimulus(4'b0110, 4'b0000, ht(1, 2'b10), 1'b1);
         nm = $sformatf("hold_xfer%0d", t);
         if (t <= 16) checkOutput(nm, 4'b0010, 2'd1, 2'd1, 1'b0, 2'd1);
         else         checkOutput(nm, 4'b0100, 2'd2, 2'd1, 1'b0, 2'd1);
      end
      applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b1);
      checkOutput("hold_park", 4'b0001, 2'd0, 2'd2, 1'b0, 2'd0);

      // Lone streamer keeps the bus; its expired budget restarts instead of forcing a switch.
      applyStimulus(4'b0010, 4'b0000, 8'h00, 1'b1);
      checkOutput("solo_grant", 4'b0010, 2'd1, 2'd0, 1'b0, 2'd1);
      for (int t = 1; t <= 20; t++) begin
         applyStimulus(4'b0010, 4'b0000, ht(1, 2'b10), 1'b1);
         nm = $sformatf("solo_xfer%0d", t);
         checkOutput(nm, 4'b0010, 2'd1, 2'd1, 1'b0, 2'd1);
      end
      applyStimulus(4'b0110, 4'b0000, ht(1, 2'b10), 1'b1);
      checkOutput("solo_budget_restarted", 4'b0010, 2'd1, 2'd1, 1'b0, 2'd1);
      applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b1);
      checkOutput("solo_park", 4'b0001, 2'd0, 2'd1, 1'b0, 2'd0);

      // Everyone requests with IDLE boundaries: strict rotation 1,2,3,0,...
      for (int r = 1; r <= 8; r++) begin
         applyStimulus(4'b1111, 4'b0000, 8'h00, 1'b1);
         g  = 4'b0001 << (r % 4);
         nm = $sformatf("rr%0d", r);
         checkOutput(nm, g, 2'(r % 4), 2'((r - 1) % 4), 1'b0, 2'd1);
         compared++;
         if (!$onehot(hgrant)) begin
            mismatched++;
            $display("[TB] FAIL rr_onehot%0d: got grant=%b, expected a one-hot grant", r, hgrant);
         end
      end

      // Locked burst by master 2, aborted by an asynchronous reset mid-cycle.
      applyStimulus(4'b0100, 4'b0100, 8'h00, 1'b1);
      checkOutput("burst_lock", 4'b0100, 2'd2, 2'd0, 1'b1, 2'd2);
      applyStimulus(4'b0100, 4'b0100, ht(2, 2'b10), 1'b1);
      checkOutput("burst_nonseq", 4'b0100, 2'd2, 2'd2, 1'b1, 2'd2);
      applyStimulus(4'b0100, 4'b0100, ht(2, 2'b11), 1'b1);
      checkOutput("burst_seq", 4'b0100, 2'd2, 2'd2, 1'b1, 2'd2);
      #2;
      hreset = 1'b1;
      #1;
      checkOutput("async_reset", 4'b0001, 2'd0, 2'd0, 1'b0, 2'd0);
      hreset = 1'b0;
      applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b1);
      checkOutput("after_reset", 4'b0001, 2'd0, 2'd0, 1'b0, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
